// File: rtl/fifo_rr_write_arbiter.sv
// ============================================================================
// Module   : fifo_rr_write_arbiter
// Brief    : Round-robin, burst-granular arbiter sharing one FIFO write port
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_rr_write_arbiter #(
   parameter int DW = 8,
   parameter int NR = 4,
   parameter int BL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NR-1:0]     req,
   input  logic [NR*DW-1:0]  data,
   input  logic [NR-1:0]     last,
   output logic [NR-1:0]     ack,
   output logic [NR-1:0]     gnt,
   output logic              busy,
   output logic [DW-1:0]     fifo_din,
   output logic              fifo_we,
   input  logic              fifo_full,
   input  logic              fifo_full_n
);

   localparam int PW = (NR > 1) ? $clog2(NR) : 1;
   localparam logic [7:0]    c_CNT_LAST = 8'(BL - 1);
   localparam logic [PW-1:0] c_IDX_LAST = PW'(NR - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t          r_state, w_state_nx;
   logic [NR-1:0]   r_gnt, w_gnt_nx;
   logic [7:0]      r_cnt, w_cnt_nx;
   logic [PW-1:0]   r_ptr, w_ptr_nx;
   logic [PW-1:0]   r_idx, w_idx_nx;

   logic            w_found;
   logic [PW-1:0]   w_win;
   logic            w_greq;
   logic            w_glast;
   logic [DW-1:0]   w_gdata;
   logic            w_we;
   logic            w_exit;

   // First requester at or after r_ptr, wrapping modulo NR.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NR; k++) begin
         if (!w_found && req[(int'(r_ptr) + k) % NR]) begin
            w_found = 1'b1;
            w_win   = PW'((int'(r_ptr) + k) % NR);
         end
      end
   end

   assign w_greq  = req[r_idx];
   assign w_glast = last[r_idx];
   assign w_gdata = data[int'(r_idx)*DW +: DW];

   assign busy     = (r_state == S_BURST);
   assign w_we     = busy & w_greq & ~fifo_full;
   assign fifo_we  = w_we;
   assign fifo_din = busy ? w_gdata : '0;
   assign ack      = r_gnt & {NR{w_we}};
   assign gnt      = r_gnt;

   // A withdrawn request ends the burst even while the FIFO is full.
   assign w_exit = busy & ((w_we & (w_glast | (r_cnt == c_CNT_LAST))) | ~w_greq);

   always_comb begin
      w_state_nx = r_state;
      w_gnt_nx   = r_gnt;
      w_cnt_nx   = r_cnt;
      w_ptr_nx   = r_ptr;
      w_idx_nx   = r_idx;
      case (r_state)
         S_IDLE: begin
            if (w_found && !fifo_full_n) begin
               w_state_nx      = S_BURST;
               w_gnt_nx        = '0;
               w_gnt_nx[w_win] = 1'b1;
               w_cnt_nx        = '0;
               w_idx_nx        = w_win;
            end
         end
         S_BURST: begin
            if (w_exit) begin
               w_state_nx = S_IDLE;
               w_gnt_nx   = '0;
               w_cnt_nx   = '0;
               w_ptr_nx   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else if (w_we) begin
               w_cnt_nx = r_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_gnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_gnt   <= w_gnt_nx;
         r_cnt   <= w_cnt_nx;
         r_ptr   <= w_ptr_nx;
         r_idx   <= w_idx_nx;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_write_arbiter.sv
// ============================================================================
// Module   : tb_fifo_rr_write_arbiter
// Brief    : Randomized self-checking bench against a transaction-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rr_write_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int BL = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req;
   logic [NR*DW-1:0]  data;
   logic [NR-1:0]     last;
   logic [NR-1:0]     ack;
   logic [NR-1:0]     gnt;
   logic              busy;
   logic [DW-1:0]     fifo_din;
   logic              fifo_we;
   logic              fifo_full;
   logic              fifo_full_n;

   int n_chk = 0;
   int n_err = 0;

   // Model: who owns the port, words written in this grant, next search start.
   int m_owner = -1;
   int m_words = 0;
   int m_next  = 0;
   int wr_cnt  = 0;

   fifo_rr_write_arbiter #(.DW(DW), .NR(NR), .BL(BL)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .data        (data),
      .last        (last),
      .ack         (ack),
      .gnt         (gnt),
      .busy        (busy),
      .fifo_din    (fifo_din),
      .fifo_we     (fifo_we),
      .fifo_full   (fifo_full),
      .fifo_full_n (fifo_full_n)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One cycle: check outputs mid-cycle, then advance the model on the edge.
   task automatic step();
      logic [NR-1:0] e_gnt;
      logic          e_we;
      bit            done;
      #4;
      e_gnt = '0;
      if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
      e_we = (m_owner >= 0) && req[m_owner] && !fifo_full;
      check_val("gnt",  32'(gnt),     32'(e_gnt));
      check_val("busy", 32'(busy),    32'(m_owner >= 0));
      check_val("we",   32'(fifo_we), 32'(e_we));
      check_val("ack",  32'(ack),     e_we ? 32'(e_gnt) : 32'd0);
      if (e_we) check_val("din", 32'(fifo_din), 32'(data[m_owner*DW +: DW]));
      if (fifo_we) wr_cnt++;
      @(posedge clk);
      if (rst) begin
         m_owner = -1; m_words = 0; m_next = 0;
      end else if (m_owner < 0) begin
         if (req != 0 && !fifo_full_n) begin
            for (int k = 0; k < NR; k++) begin
               if (m_owner < 0 && req[(m_next + k) % NR]) m_owner = (m_next + k) % NR;
            end
            m_words = 0;
         end
      end else begin
         done = !req[m_owner];
         if (e_we) begin
            m_words++;
            if (last[m_owner] || m_words == BL) done = 1;
         end
         if (done) begin
            check_val("words_le_bl", 32'(m_words <= BL), 32'd1);
            m_next  = (m_owner + 1) % NR;
            m_owner = -1;
            m_words = 0;
         end
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; req = '0; data = '0; last = '0;
      fifo_full = 1'b0; fifo_full_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("rst_gnt",  32'(gnt),     32'd0);
      check_val("rst_busy", 32'(busy),    32'd0);
      check_val("rst_we",   32'(fifo_we), 32'd0);

      // Saturated load from reset: 4 writes + 1 bubble per grant.
      wr_cnt = 0;
      req = '1;
      for (int c = 0; c < 30; c++) begin
         data = {$urandom, $urandom};
         step();
      end
      check_val("sat_writes_30cyc", 32'(wr_cnt), 32'd24);

      // Reset mid-burst, then 1010 must grant requester 1 before 3.
      rst = 1'b1; step();
      rst = 1'b0; req = 4'b1010; last = '0;
      step();
      check_val("post_rst_gnt1", 32'(gnt), 32'b0010);
      for (int c = 0; c < 5; c++) step();
      check_val("post_rst_gnt3", 32'(gnt), 32'b1000);

      // fifo_full_n holds off admission.
      req = '0; step(); step(); step(); step(); step(); step();
      fifo_full_n = 1'b1; req = 4'b1010;
      for (int c = 0; c < 5; c++) step();
      check_val("full_n_hold", 32'(gnt), 32'd0);
      fifo_full_n = 1'b0;
      step();

      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NR; i++) begin
            req[i]  = ($urandom_range(0, 9) < 8);
            last[i] = ($urandom_range(0, 99) < 15);
         end
         data        = {$urandom, $urandom};
         fifo_full   = ($urandom_range(0, 99) < 15);
         fifo_full_n = ($urandom_range(0, 99) < 20);
         rst         = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_rr_write_arbiter.md
Name: fifo_rr_write_arbiter

Overview:
Shares the write port of one single-clock FIFO between nr producers.
- Round-robin arbitration at burst granularity: a grant holds for one packet or at most bl words, whichever ends first.
- Admission control uses the FIFO's almost-full flag: a burst is only started when the FIFO has room for it.
- Sits directly in front of the FIFO write side: drives din/we, consumes full/full_n.

Parameters:
dw, 8, data width per requester and to the FIFO
nr, 4, number of requesters (2..8)
bl, 4, maximum words per grant (1..256)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  nr  per-requester "word valid"; bit i belongs to requester i
data  in  nr*dw  requester i's word in bits [i*dw +: dw]
last  in  nr  marks requester i's current word as end of packet
ack  out  nr  word of requester i written to FIFO this cycle
gnt  out  nr  registered one-hot grant; all zero in IDLE
busy  out  1  high in BURST state
fifo_din  out  dw  word to FIFO
fifo_we  out  1  FIFO write enable
fifo_full  in  1  FIFO full (combinational flag)
fifo_full_n  in  1  FIFO almost full: fewer than n free slots; integration guarantees n >= bl

Behaviour:
Reset (rst=1 at clk edge): state=IDLE, gnt=0, cnt=0, ptr=0, busy=0. Consequently ack=0 and fifo_we=0 from the following cycle. rst has priority over all other events, including mid-burst; an interrupted burst is dropped with no further writes.

Registers:
- state: IDLE | BURST
- gnt: nr bits, one-hot or zero
- cnt: words written in the current burst, 8 bits
- ptr: index where the next search starts, clog2(nr) bits

IDLE:
- fifo_we=0, ack=0.
- Grant condition: |req and !fifo_full_n.
- On grant: search from ptr upward, modulo nr; the first i with req[i]=1 wins.
- Next edge: gnt<=onehot(i), cnt<=0, state<=BURST.
- Arbitration latency is one cycle; no write occurs in the arbitration cycle.
- If fifo_full_n=1, stay in IDLE regardless of req.

BURST (g = granted index):
- Combinational outputs: fifo_din=data[g]; fifo_we=req[g] & !fifo_full; ack=gnt & {nr{fifo_we}}.
- On a write: cnt<=cnt+1.
- Exit to IDLE on the edge where any of the following holds:
  a) fifo_we & last[g] (packet end);
  b) fifo_we & cnt==bl-1 (burst limit; rest of the packet re-arbitrates);
  c) !req[g] (requester withdrew; abort, no write).
- On exit: gnt<=0, ptr<=(g+1) mod nr.
- fifo_full=1 while req[g]=1: stall. No write, cnt holds, grant holds; not an exit.
- fifo_full_n is ignored in BURST.
- After every burst there is exactly one IDLE cycle (the re-arbitration bubble).
- Requests from non-granted requesters are never acked; their data/last are don't-care.

Invariants:
- fifo_we implies exactly one gnt bit set.
- Never fifo_we & fifo_full.
- cnt <= bl-1 at all times.
- Words per grant <= bl.

Test Plan:
1. nr=4, bl=4, FIFO empty. req0 asserted at cycle 0 with a 3-word packet (last on 3rd word) -> gnt=0001 at cycle 1; fifo_we and ack[0] high cycles 1-3, fifo_din = words 0,1,2; gnt=0 and busy=0 at cycle 4; ptr=1.
2. All four req held high, packets of 10 words -> grant order 0,1,2,3,0,1. Each grant writes exactly 4 words, followed by one idle cycle; 24 writes in 30 cycles.
3. Single 4-word burst; fifo_full high at the 2nd word for 2 cycles -> fifo_we low during those 2 cycles; cnt frozen at 1; all 4 words written, in order, with no duplicates; burst ends after the 4th write.
4. fifo_full_n=1 in IDLE with req=1010 for 5 cycles, then dropped -> gnt stays 0 during the 5 cycles; gnt=0010 on the cycle after fifo_full_n falls.
5. rst pulsed during requester 2's 2nd word -> next cycle gnt=0, fifo_we=0, ptr=0. With req=1010 afterwards, requester 1 is granted before requester 3.
6. req1 drops after 1 write of a 4-word grant -> exit to IDLE with no further acks to requester 1; ptr=2; a pending req3 is granted next.
